// File: rtl/frame_strobe_ctrl.sv
// Per-column frame strobe generator: filters frame-write commands for this column
// and drives a glitch-free one-hot FrameStrobe as setup / strobe / guard cycles.
module frame_strobe_ctrl #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int ColSelectWidth   = 5,
  parameter int ColumnId         = 0,
  parameter int StrobeCycles     = 2
) (
  input  logic                        UserCLK,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ColSelectWidth-1:0]   cmd_col,
  input  logic [FrameSelectWidth-1:0] cmd_frame,
  input  logic                        cmd_bcast,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [15:0]                 strobe_count
);

  if (StrobeCycles < 1 || StrobeCycles > 15) begin : gen_bad_strobe_cycles
    $error("frame_strobe_ctrl: StrobeCycles must be in 1..15");
  end
  if ((2 ** FrameSelectWidth) < MaxFramesPerCol) begin : gen_bad_frame_width
    $error("frame_strobe_ctrl: FrameSelectWidth too narrow for MaxFramesPerCol");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  localparam logic [FrameSelectWidth:0]      FrameLimit = (FrameSelectWidth+1)'(MaxFramesPerCol);
  localparam logic [ColSelectWidth-1:0]      ColId      = ColSelectWidth'(ColumnId);
  localparam logic [3:0]                     CntLoad    = 4'(StrobeCycles - 1);
  localparam logic [MaxFramesPerCol-1:0]     OneHotLsb  = MaxFramesPerCol'(1);

  state_e                      state_q, state_d;
  logic [FrameSelectWidth-1:0] frame_q, frame_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [MaxFramesPerCol-1:0]  strobe_q, strobe_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic [15:0]                 count_q, count_d;

  logic handshake, match, in_range;

  assign cmd_ready = (state_q == IDLE) & ~rst;
  assign handshake = cmd_valid & cmd_ready;
  assign match     = cmd_bcast | (cmd_col == ColId);
  assign in_range  = {1'b0, cmd_frame} < FrameLimit;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d  = state_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    count_d  = count_q;

    unique case (state_q)
      IDLE: begin
        if (handshake && match) begin
          if (in_range) begin
            state_d = SETUP;
            frame_d = cmd_frame;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        // Strobe is built from the captured frame so it is stable for its whole width.
        state_d  = STROBE;
        cnt_d    = CntLoad;
        strobe_d = OneHotLsb << frame_q;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d  = HOLD;
          strobe_d = '0;
          done_d   = 1'b1;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        strobe_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      cnt_q    <= '0;
      strobe_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign FrameStrobe  = strobe_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign strobe_count = count_q;

endmodule

// File: tb/tb_frame_strobe_ctrl.sv
// Directed bench for frame_strobe_ctrl: ColumnId=3 with StrobeCycles=2 (main) and
// StrobeCycles=1 (second instance); inputs change on falling edges, outputs checked there.
module tb_frame_strobe_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_valid1;
  logic [4:0]  cmd_col;
  logic [4:0]  cmd_frame;
  logic        cmd_bcast;

  logic        cmd_ready, busy, done, err;
  logic [19:0] frame_strobe;
  logic [15:0] strobe_count;

  logic        cmd_ready1, busy1, done1, err1;
  logic [19:0] frame_strobe1;
  logic [15:0] strobe_count1;

  int n_vec = 0;
  int n_bad = 0;

  frame_strobe_ctrl #(.ColumnId(3), .StrobeCycles(2)) dut (
    .UserCLK(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_col(cmd_col), .cmd_frame(cmd_frame), .cmd_bcast(cmd_bcast),
    .FrameStrobe(frame_strobe), .busy(busy), .done(done), .err(err),
    .strobe_count(strobe_count)
  );

  frame_strobe_ctrl #(.ColumnId(3), .StrobeCycles(1)) dut1 (
    .UserCLK(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_col(cmd_col), .cmd_frame(cmd_frame), .cmd_bcast(cmd_bcast),
    .FrameStrobe(frame_strobe1), .busy(busy1), .done(done1), .err(err1),
    .strobe_count(strobe_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle and check strobe plus {cmd_ready, busy, done, err}.
  task automatic cyc(input string tag, input logic [19:0] exp_strobe, input logic [3:0] exp_flags);
    @(negedge clk);
    check({tag, ".strobe"}, 32'(frame_strobe), 32'(exp_strobe));
    check({tag, ".flags"}, 32'({cmd_ready, busy, done, err}), 32'(exp_flags));
  endtask

  task automatic issue(input logic [4:0] col, input logic [4:0] frame, input logic bcast);
    cmd_col   = col;
    cmd_frame = frame;
    cmd_bcast = bcast;
    cmd_valid = 1'b1;
  endtask

  // Full matched write with StrobeCycles=2, starting from IDLE at a falling edge.
  task automatic write_seq(input string tag, input logic [4:0] col, input logic [4:0] frame,
                           input logic bcast, input logic [19:0] exp_strobe);
    issue(col, frame, bcast);
    cyc({tag, ".c1"}, 20'h0, 4'b0100);
    cmd_valid = 1'b0;
    cyc({tag, ".c2"}, exp_strobe, 4'b0100);
    cyc({tag, ".c3"}, exp_strobe, 4'b0100);
    cyc({tag, ".c4"}, 20'h0, 4'b0110);
    cyc({tag, ".c5"}, 20'h0, 4'b1000);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid1 = 1'b0;
    cmd_col = '0; cmd_frame = '0; cmd_bcast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.strobe", 32'(frame_strobe), 32'h0);
    check("rst.flags", 32'({cmd_ready, busy, done, err}), 32'h0);
    check("rst.count", 32'(strobe_count), 32'h0);
    rst = 1'b0;
    #1;
    check("rst.ready_after", 32'(cmd_ready), 32'h1);

    // 1: basic matched write
    write_seq("t1", 5'd3, 5'd7, 1'b0, 20'h00080);
    check("t1.count", 32'(strobe_count), 32'd1);

    // 2: other column ignored, then same command as broadcast
    issue(5'd5, 5'd2, 1'b0);
    cyc("t2.c1", 20'h0, 4'b1000);
    cmd_valid = 1'b0;
    cyc("t2.c2", 20'h0, 4'b1000);
    cyc("t2.c3", 20'h0, 4'b1000);
    cyc("t2.c4", 20'h0, 4'b1000);
    write_seq("t2b", 5'd5, 5'd2, 1'b1, 20'h00004);
    check("t2.count", 32'(strobe_count), 32'd2);

    // 3: out-of-range frames raise err, next command accepted the following cycle
    issue(5'd3, 5'd20, 1'b0);
    cyc("t3.c1", 20'h0, 4'b1001);
    issue(5'd3, 5'd31, 1'b0);
    cyc("t3.c2", 20'h0, 4'b1001);
    cmd_valid = 1'b0;
    cyc("t3.c3", 20'h0, 4'b1000);
    check("t3.count", 32'(strobe_count), 32'd2);

    // 4: back-to-back with cmd_valid held; fields change while busy
    issue(5'd3, 5'd0, 1'b0);
    cyc("t4.a1", 20'h0, 4'b0100);
    cmd_frame = 5'd19;
    cyc("t4.a2", 20'h00001, 4'b0100);
    cyc("t4.a3", 20'h00001, 4'b0100);
    cyc("t4.a4", 20'h0, 4'b0110);
    cyc("t4.a5", 20'h0, 4'b1000);
    cyc("t4.b1", 20'h0, 4'b0100);
    cmd_valid = 1'b0;
    cyc("t4.b2", 20'h80000, 4'b0100);
    cyc("t4.b3", 20'h80000, 4'b0100);
    cyc("t4.b4", 20'h0, 4'b0110);
    cyc("t4.b5", 20'h0, 4'b1000);
    check("t4.count", 32'(strobe_count), 32'd4);

    // 5: reset in the middle of the strobe
    issue(5'd3, 5'd9, 1'b0);
    cyc("t5.c1", 20'h0, 4'b0100);
    cmd_valid = 1'b0;
    cyc("t5.c2", 20'h00200, 4'b0100);
    rst = 1'b1;
    cyc("t5.rst", 20'h0, 4'b0000);
    check("t5.count", 32'(strobe_count), 32'd0);
    rst = 1'b0;
    cyc("t5.after", 20'h0, 4'b1000);

    // 6: saturation of strobe_count
    force dut.count_q = 16'hFFFE;
    @(negedge clk);
    release dut.count_q;
    check("t6.preload", 32'(strobe_count), 32'h0000FFFE);
    write_seq("t6a", 5'd3, 5'd1, 1'b0, 20'h00002);
    check("t6.count_a", 32'(strobe_count), 32'h0000FFFF);
    write_seq("t6b", 5'd3, 5'd2, 1'b0, 20'h00004);
    check("t6.count_b", 32'(strobe_count), 32'h0000FFFF);

    // 6b: StrobeCycles=1 instance strobes for exactly one cycle
    cmd_col = 5'd3; cmd_frame = 5'd4; cmd_bcast = 1'b0;
    cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    check("s1.c1.strobe", 32'(frame_strobe1), 32'h0);
    check("s1.c1.busy", 32'(busy1), 32'h1);
    @(negedge clk);
    check("s1.c2.strobe", 32'(frame_strobe1), 32'h00010);
    @(negedge clk);
    check("s1.c3.strobe", 32'(frame_strobe1), 32'h0);
    check("s1.c3.done", 32'(done1), 32'h1);
    @(negedge clk);
    check("s1.c4.ready", 32'({cmd_ready1, busy1, done1}), 32'b100);
    check("s1.count", 32'(strobe_count1), 32'd1);
    check("s1.main_idle", 32'({cmd_ready, busy, frame_strobe}), {2'b10, 20'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
